// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits, LSB first, one start bit, one stop bit, no parity.
// Bit timing comes from a 12-bit counter that spans clock_divide cycles per bit.
module uart_tx #(
  parameter int clk_freq  = 50000000,
  parameter int baud_rate = 19200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data_in,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int clock_divide = clk_freq / baud_rate;
  localparam logic [11:0] last_count = 12'(clock_divide - 1);

  // Reject divides the 12-bit counter cannot time, or that leave no room for a bit.
  if (clock_divide < 2 || clock_divide > 4096) begin : g_bad_divide
    $error("uart_tx: clock_divide %0d outside legal range 2..4096", clock_divide);
  end

  typedef enum logic [2:0] {
    tx_IDLE,
    tx_START,
    tx_DATA,
    tx_STOP,
    tx_DONE
  } state_t;

  state_t      state;
  logic [11:0] count;
  logic [2:0]  bit_index;
  logic [7:0]  shift_reg;
  logic        bit_end;

  assign bit_end  = (count == last_count);
  assign tx_ready = (state == tx_IDLE);
  assign tx_busy  = ~tx_ready;

  // Frame sequencer: accepts a byte in idle and drives the registered line and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= tx_IDLE;
      count     <= '0;
      bit_index <= '0;
      shift_reg <= '0;
      tx        <= 1'b1;
      tx_done   <= 1'b0;
    end else begin
      case (state)
        tx_IDLE: begin
          tx      <= 1'b1;
          tx_done <= 1'b0;
          if (tx_valid) begin
            shift_reg <= tx_data_in;
            count     <= '0;
            bit_index <= '0;
            tx        <= 1'b0;
            state     <= tx_START;
          end
        end
        tx_START: begin
          if (bit_end) begin
            count     <= '0;
            tx        <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
            state     <= tx_DATA;
          end else begin
            count <= count + 12'd1;
          end
        end
        tx_DATA: begin
          if (bit_end) begin
            count <= '0;
            if (bit_index == 3'd7) begin
              bit_index <= '0;
              tx        <= 1'b1;
              state     <= tx_STOP;
            end else begin
              bit_index <= bit_index + 3'd1;
              tx        <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
            end
          end else begin
            count <= count + 12'd1;
          end
        end
        tx_STOP: begin
          if (bit_end) begin
            count   <= '0;
            tx_done <= 1'b1;
            state   <= tx_DONE;
          end else begin
            count <= count + 12'd1;
          end
        end
        tx_DONE: begin
          tx      <= 1'b1;
          tx_done <= 1'b0;
          state   <= tx_IDLE;
        end
        default: begin
          state     <= tx_IDLE;
          count     <= '0;
          bit_index <= '0;
          tx        <= 1'b1;
          tx_done   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx with D = 16: handshakes feed a frame queue, a negedge monitor
// compares the line against the frame shape and decodes each byte.
module tb_uart_tx;

  localparam int D = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_valid;
  logic [7:0] tx_data_in;
  logic       tx_ready;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  uart_tx #(.clk_freq(16), .baud_rate(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_valid   (tx_valid),
    .tx_data_in (tx_data_in),
    .tx_ready   (tx_ready),
    .tx         (tx),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         hs;
  } frame_t;

  frame_t     q[$];
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  int         hs_count = 0;
  int         last_hs = 0;
  int         frames_done = 0;
  bit         armed = 0;
  bit         rst_prev = 0;
  logic [7:0] rx_byte = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%b want=%b", name, cyc, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  // Reference model and monitor: expected line derived from handshake cycle and frame layout.
  always @(negedge clk) begin
    logic e_tx, e_rdy, e_done;
    int   k;
    e_tx = 1'b1; e_rdy = 1'b1; e_done = 1'b0; k = -1;
    if (armed) begin
      if (!rst_prev && q.size() > 0) begin
        k     = cyc - q[0].hs;
        e_rdy = 1'b0;
        if (k <= D)            e_tx = 1'b0;
        else if (k <= 9 * D)   e_tx = q[0].data[(k - 1) / D - 1];
        else if (k <= 10 * D)  e_tx = 1'b1;
        else begin e_tx = 1'b1; e_done = 1'b1; end
      end
      chk("tx", tx, e_tx);
      chk("tx_done", tx_done, e_done);
      chk("tx_ready", tx_ready, e_rdy);
      chk("tx_busy", tx_busy, ~e_rdy);
      if (k > D && k <= 9 * D && ((k - 1) % D) == D / 2)
        rx_byte[(k - 1) / D - 1] = tx;
      if (k == 10 * D + 1) begin
        chk_int("rx_byte", int'(rx_byte), int'(q[0].data));
        frames_done++;
        void'(q.pop_front());
      end
    end
    if (rst === 1'b1) begin
      q.delete();
      rst_prev = 1;
      armed    = 1;
    end else begin
      rst_prev = 0;
      if (armed && tx_valid && e_rdy) begin
        q.push_back('{data: tx_data_in, hs: cyc});
        last_hs = cyc;
        hs_count++;
      end
    end
  end

  task automatic wait_hs(input int start);
    for (int n = 0; n < 400; n++) begin
      @(posedge clk); #2;
      if (hs_count != start) break;
    end
    chk_int("handshake_timeout", int'(hs_count != start), 1);
  endtask

  task automatic send(input logic [7:0] b);
    int start;
    start = hs_count;
    tx_valid = 1'b1;
    tx_data_in = b;
    wait_hs(start);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    for (n = 0; n < 400; n++) begin
      @(posedge clk); #2;
      if (q.size() == 0) break;
    end
    chk_int("idle_timeout", int'(q.size()), 0);
  endtask

  initial begin
    int h1, h2, done0;
    rst = 1'b1; tx_valid = 1'b0; tx_data_in = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;

    // Basic frame
    send(8'hA5);
    wait_idle();

    // Continuous valid: back-to-back frames, 162 cycles apart
    tx_valid = 1'b1; tx_data_in = 8'h00;
    wait_hs(hs_count);
    h1 = last_hs;
    tx_data_in = 8'hFF;
    wait_hs(hs_count);
    h2 = last_hs;
    tx_valid = 1'b0;
    chk_int("hs_spacing", h2 - h1, 10 * D + 2);
    wait_idle();

    // Data input changes mid-frame
    send(8'h81);
    repeat (19) @(posedge clk);
    #2 tx_data_in = 8'h3C;
    wait_idle();

    // Valid pulse while busy is ignored
    send(8'h5A);
    repeat (30) @(posedge clk);
    #2 tx_valid = 1'b1; tx_data_in = 8'h11;
    @(posedge clk);
    #2 tx_valid = 1'b0;
    wait_idle();
    chk_int("hs_after_busy_pulse", hs_count, 5);

    // Reset mid-frame with valid asserted alongside
    done0 = frames_done;
    send(8'hC3);
    repeat (49) @(posedge clk);
    #2 rst = 1'b1; tx_valid = 1'b1; tx_data_in = 8'h99;
    @(posedge clk);
    #2 rst = 1'b0; tx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk_int("aborted_frame_not_done", frames_done, done0);
    send(8'h55);
    wait_idle();
    chk_int("frame_after_reset", frames_done, done0 + 1);

    // Random bytes with random gaps and data wiggle during frames
    for (int i = 0; i < 12; i++) begin
      send(8'($urandom_range(255)));
      if ($urandom_range(1) == 1) begin
        repeat ($urandom_range(100, 1)) @(posedge clk);
        #2 tx_data_in = 8'($urandom_range(255));
      end
      wait_idle();
      repeat ($urandom_range(3)) @(posedge clk);
      #2;
    end
    chk_int("frames_total", frames_done, done0 + 13);

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
